// File: rtl/uart_packet_transceiver.sv
// Full-duplex UART on a single system clock. Packet transmitter sends up to
// MAX_BYTES characters per load; receiver samples mid-bit and flags parity/framing errors.
module uart_packet_transceiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MAX_BYTES    = 11
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 rx,
    output logic                                 tx,
    output logic [DATA_BITS-1:0]                 rx_data,
    output logic                                 rx_valid,
    output logic                                 rx_parity_err,
    output logic                                 rx_frame_err,
    input  logic [MAX_BYTES*DATA_BITS-1:0]       tx_bytes,
    input  logic [$clog2(MAX_BYTES+1)-1:0]       tx_num_bytes,
    input  logic                                 tx_valid,
    output logic                                 tx_ready
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int NW    = $clog2(MAX_BYTES + 1);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int BUF_W = MAX_BYTES * DATA_BITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [NW-1:0] MAX_NUM   = NW'(MAX_BYTES);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // ------------------------------------------------------------------ TX
    tx_state_t            tx_state_reg, tx_state_next;
    logic [CW-1:0]        tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]        tx_bit_reg, tx_bit_next;
    logic [NW-1:0]        tx_left_reg, tx_left_next;
    logic [BUF_W-1:0]     tx_buf_reg, tx_buf_next;
    logic                 tx_reg, tx_line_next;
    logic [DATA_BITS-1:0] tx_char_next;
    logic                 tx_cnt_wrap;
    logic [NW-1:0]        tx_num_clamped;

    assign tx_cnt_wrap    = (tx_cnt_reg == CNT_LAST);
    assign tx_num_clamped = (tx_num_bytes > MAX_NUM) ? MAX_NUM : tx_num_bytes;
    assign tx             = tx_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_left_reg  <= '0;
            tx_buf_reg   <= '0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_left_reg  <= tx_left_next;
            tx_buf_reg   <= tx_buf_next;
            tx_reg       <= tx_line_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_left_next  = tx_left_reg;
        tx_buf_next   = tx_buf_reg;
        if (tx_state_reg == TX_IDLE) begin
            if (tx_valid && (tx_num_bytes != '0)) begin
                tx_state_next = TX_START;
                tx_cnt_next   = '0;
                tx_bit_next   = '0;
                tx_left_next  = tx_num_clamped;
                tx_buf_next   = tx_bytes;
            end
        end else begin
            tx_cnt_next = tx_cnt_wrap ? '0 : tx_cnt_reg + CW'(1);
            if (tx_cnt_wrap) begin
                case (tx_state_reg)
                    TX_START: begin
                        tx_state_next = TX_DATA;
                        tx_bit_next   = '0;
                    end
                    TX_DATA: begin
                        if (tx_bit_reg == BIT_LAST) begin
                            tx_state_next = HAS_PAR ? TX_PARITY : TX_STOP;
                            tx_bit_next   = '0;
                        end else begin
                            tx_bit_next = tx_bit_reg + BW'(1);
                        end
                    end
                    TX_PARITY: begin
                        tx_state_next = TX_STOP;
                        tx_bit_next   = '0;
                    end
                    default: begin
                        // Next character follows with no idle gap
                        if (tx_bit_reg == STOP_LAST) begin
                            tx_bit_next = '0;
                            if (tx_left_reg > NW'(1)) begin
                                tx_state_next = TX_START;
                                tx_left_next  = tx_left_reg - NW'(1);
                                tx_buf_next   = tx_buf_reg << DATA_BITS;
                            end else begin
                                tx_state_next = TX_IDLE;
                                tx_left_next  = '0;
                            end
                        end else begin
                            tx_bit_next = tx_bit_reg + BW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Line level is computed from the next state so tx is a plain flop
    always_comb begin
        tx_ready     = (tx_state_reg == TX_IDLE);
        tx_char_next = tx_buf_next[BUF_W-1 -: DATA_BITS];
        case (tx_state_next)
            TX_START:  tx_line_next = 1'b0;
            TX_DATA:   tx_line_next = tx_char_next[tx_bit_next];
            TX_PARITY: tx_line_next = (^tx_char_next) ^ PAR_ODD;
            default:   tx_line_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------ RX
    logic                 rx_meta_reg, rx_sync_reg;
    rx_state_t            rx_state_reg, rx_state_next;
    logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]        rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_pend_reg, rx_pend_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 rx_perr_reg, rx_perr_next;
    logic                 rx_ferr_reg, rx_ferr_next;
    logic                 rx_cnt_wrap;

    assign rx_cnt_wrap   = (rx_cnt_reg == CNT_LAST);
    assign rx_data       = rx_data_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_parity_err = rx_perr_reg;
    assign rx_frame_err  = rx_ferr_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_pend_reg  <= 1'b0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_perr_reg  <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_pend_reg  <= rx_pend_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            rx_perr_reg  <= rx_perr_next;
            rx_ferr_reg  <= rx_ferr_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_pend_next  = rx_pend_reg;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_sync_reg) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                // Half-bit resample rejects short low glitches
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                rx_cnt_next = rx_cnt_wrap ? '0 : rx_cnt_reg + CW'(1);
                if (rx_cnt_wrap) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == BIT_LAST) begin
                        rx_state_next = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + BW'(1);
                    end
                end
            end
            RX_PARITY: begin
                rx_cnt_next = rx_cnt_wrap ? '0 : rx_cnt_reg + CW'(1);
                if (rx_cnt_wrap) begin
                    rx_pend_next  = rx_sync_reg ^ (^rx_shift_reg) ^ PAR_ODD;
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_next = rx_cnt_wrap ? '0 : rx_cnt_reg + CW'(1);
                if (rx_cnt_wrap) begin
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_BREAK;
                end
            end
            default: begin
                if (rx_sync_reg) begin
                    rx_state_next = RX_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rx_valid_next = (rx_state_reg == RX_STOP) && rx_cnt_wrap;
        rx_data_next  = rx_data_reg;
        rx_perr_next  = rx_perr_reg;
        rx_ferr_next  = rx_ferr_reg;
        if (rx_valid_next) begin
            rx_data_next = rx_shift_reg;
            rx_perr_next = HAS_PAR ? rx_pend_reg : 1'b0;
            rx_ferr_next = ~rx_sync_reg;
        end
    end

endmodule

// File: doc/uart_packet_transceiver.md
Name: uart_packet_transceiver

Overview:
Parametrised full-duplex UART for the CPLD command/telemetry link. It runs on a single system clock with an internal bit-rate counter, so no separate oversample clock is needed. Data width, parity and stop bits are configurable. The transmitter sends packets of up to MAX_BYTES characters from one parallel load. The receiver uses a metastability synchroniser, mid-bit sampling, glitch rejection and parity/framing error flags.

Parameters:
CLKS_PER_BIT, 8, clock cycles per bit period; legal values are 4 to 65535.
DATA_BITS, 8, character width; legal values are 5 to 9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, TX stop bits (1 or 2); RX checks only the first stop bit.
MAX_BYTES, 11, packet buffer depth in characters.

Ports:
clock  input  1  system clock; all logic is on its rising edge
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial in, asynchronous to clock, idles high
tx  output  1  serial out, registered, idles high
rx_data  output  DATA_BITS  last received character
rx_valid  output  1  one-cycle pulse when rx_data and error flags update
rx_parity_err  output  1  parity mismatch on last character; held until next rx_valid
rx_frame_err  output  1  stop bit sampled low on last character; held until next rx_valid
tx_bytes  input  MAX_BYTES*DATA_BITS  packet; character 0 is in the most significant slice
tx_num_bytes  input  $clog2(MAX_BYTES+1)  number of characters to send
tx_valid  input  1  load request
tx_ready  output  1  high while the transmitter is idle and can accept a packet

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, both error flags = 0.
  - Synchroniser flops reset to 1.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame; there is no partial output.
- Frame format: start(0), data bits LSB first, optional parity, stop(1).
  - Even parity: parity bit = XOR of data bits. Odd parity: inverted XOR.
  - Frame length in cycles = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT.
- RX path: rx passes through a 2-flop synchroniser (2 cycles of latency). The FSM uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START on the first synchronised low.
  - START: wait CLKS_PER_BIT/2 (integer division), then resample. If high, treat as a glitch and return to IDLE with no output. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, shifting DATA_BITS bits. Then go to PARITY, or to STOP when PARITY = 0.
  - STOP: sample once. In the same cycle, pulse rx_valid, load rx_data, and set both error flags from this frame.
    - rx_valid fires even when errors are present.
    - Stop high -> IDLE. Stop low -> BREAK.
  - BREAK: wait for the synchronised line to go high, then IDLE. There is no start detection and no further rx_valid while in BREAK.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Load occurs when tx_valid && tx_ready.
    - tx_bytes and tx_num_bytes are captured into internal registers; later input changes have no effect.
    - tx_num_bytes = 0: no load; tx_ready stays 1.
    - tx_num_bytes > MAX_BYTES: clamped to MAX_BYTES.
  - tx_ready falls in the cycle after load and stays low for the whole packet. tx_valid is ignored while tx_ready = 0.
  - tx drives the start bit on the cycle after load (1-cycle latency), and each bit holds for exactly CLKS_PER_BIT cycles.
  - After the final stop period of a character, if characters remain: shift the buffer up by DATA_BITS and enter START on the next cycle. There is no idle gap between characters.
  - After the last character's stop period, tx_ready returns to 1. A new packet may load in that same cycle, making packets back-to-back.
- Bit-period counters use $clog2(CLKS_PER_BIT) bits and wrap to 0 at CLKS_PER_BIT-1. There is no drift across a packet.
- RX and TX are fully independent; simultaneous activity is legal.

Test Plan:
1. Defaults, tx looped to rx; load tx_num_bytes=1 with character 0 = 0xA5.
   - tx goes low 1 cycle after load; frame lasts 80 cycles.
   - Exactly one rx_valid with rx_data = 0xA5 and both error flags = 0.
2. Loopback, 3-character packet 0x01, 0x02, 0x03.
   - tx is continuous for 240 cycles with no idle gap.
   - rx_valid fires 3 times in order; tx_ready returns to 1 after the 240th bit cycle.
   - tx_valid pulsed mid-packet is ignored.
3. PARITY=1 instance; inject 0x0F with parity bit = 1 → rx_valid with rx_data = 0x0F and rx_parity_err = 1. Then inject 0x0F with parity bit = 0 → rx_parity_err clears to 0.
4. Defaults; inject 0x3C with stop bit = 0, then hold rx low for 40 cycles, then release high.
   - One rx_valid with rx_frame_err = 1, and none during the low hold.
   - A following clean 0x3C frame gives rx_frame_err = 0.
5. Drive rx low for 3 cycles (less than the 4-cycle half bit), then high → no rx_valid and the RX FSM returns to IDLE. Then send 0x55 → received correctly.
6. Assert reset_n low at character 2, bit 4 of a 3-character packet.
   - tx = 1 and tx_ready = 1 immediately, with no further bits after release.
   - A new 1-character packet 0x81 then transmits correctly.
